// File: rtl/aes_stream_pkg.sv
// Shared definitions for the AES stream datapath (input packer and output serializer).
// Holds the native block/bus widths and helpers that derive the narrowing ratio and
// the beat counter width from a wide/narrow width pair.
package aes_stream_pkg;

  localparam int unsigned AES_BLOCK_WIDTH = 128;
  localparam int unsigned AXIS_DATA_WIDTH = 32;

  // Number of narrow beats per wide word.
  function automatic int unsigned ratio_f(int unsigned in_w, int unsigned out_w);
    return in_w / out_w;
  endfunction

  // Beat counter width; clamped to 1 so a degenerate ratio still elaborates far enough
  // to hit the parameter check in the user module.
  function automatic int unsigned cnt_width_f(int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_width_serializer.sv
// stream_width_serializer: narrows wide AXI-Stream words into RATIO beats at one beat per
// clock, with no bubble between consecutive words.
//
// Ports:
//   clk, reset_n          single rising-edge clock, asynchronous active-low reset
//   in_tvalid/in_tready   wide-side handshake; in_tdata/in_tlast sampled on acceptance
//   out_tvalid/out_tready narrow-side handshake; out_tdata is the current beat slice,
//                         out_tlast marks the final beat of a word flagged in_tlast
//   busy                  holding register occupied
module stream_width_serializer
  import aes_stream_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = AES_BLOCK_WIDTH,
  parameter int unsigned OUT_WIDTH = AXIS_DATA_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic [IN_WIDTH-1:0]  in_tdata,
  input  logic                 in_tlast,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [OUT_WIDTH-1:0] out_tdata,
  output logic                 out_tlast,
  output logic                 busy
);

  localparam int unsigned RATIO = ratio_f(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned CntW  = cnt_width_f(RATIO);
  localparam logic [CntW-1:0] LastCnt = CntW'(RATIO - 1);

  if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_param_err
    $error("stream_width_serializer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
  end

  logic [IN_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                hold_last_q, hold_last_d;
  logic                hold_valid_q, hold_valid_d;
  logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;

  logic            last_beat;
  logic            out_fire;
  logic            in_fire;
  logic [CntW-1:0] beat_sel;
  logic [OUT_WIDTH-1:0] beats [RATIO];

  assign last_beat = hold_valid_q && (beat_cnt_q == LastCnt);
  assign out_fire  = hold_valid_q && out_tready;
  // Ready only depends on state and out_tready, so no in_tvalid -> out_* path exists.
  assign in_tready = reset_n && (!hold_valid_q || (last_beat && out_tready));
  assign in_fire   = in_tvalid && in_tready;

  always_comb begin
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_valid_d = hold_valid_q;
    beat_cnt_d   = beat_cnt_q;
    if (out_fire) begin
      if (last_beat) begin
        beat_cnt_d   = '0;
        hold_valid_d = 1'b0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
    // A load in the same cycle as the last beat wins, giving back-to-back words.
    if (in_fire) begin
      hold_data_d  = in_tdata;
      hold_last_d  = in_tlast;
      hold_valid_d = 1'b1;
      beat_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_valid_q <= hold_valid_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  for (genvar i = 0; i < RATIO; i++) begin : g_slice
    assign beats[i] = hold_data_q[i*OUT_WIDTH +: OUT_WIDTH];
  end

  // MSB-first walks the slices from the top down.
  assign beat_sel   = MSB_FIRST ? (LastCnt - beat_cnt_q) : beat_cnt_q;
  assign out_tdata  = beats[beat_sel];
  assign out_tvalid = hold_valid_q;
  assign out_tlast  = last_beat && hold_last_q;
  assign busy       = hold_valid_q;

endmodule

// File: tb/tb_stream_width_serializer.sv
module tb_stream_width_serializer;

  logic         clk;
  logic         reset_n;
  logic         in_tvalid;
  logic [127:0] in_tdata;
  logic         in_tlast;
  logic         out_tready;

  logic         in_tready_m, out_tvalid_m, out_tlast_m, busy_m;
  logic [31:0]  out_tdata_m;
  logic         in_tready_l, out_tvalid_l, out_tlast_l, busy_l;
  logic [31:0]  out_tdata_l;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] word;
    logic         last;
    logic [31:0]  msb_beats [4];
    logic [31:0]  lsb_beats [4];
  } vec_t;

  typedef struct {
    logic [31:0] d_msb;
    logic [31:0] d_lsb;
    logic        last;
  } beat_t;

  vec_t  vecs [3];
  beat_t sb [$];

  stream_width_serializer #(.IN_WIDTH(128), .OUT_WIDTH(32), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready_m),
    .in_tdata   (in_tdata),
    .in_tlast   (in_tlast),
    .out_tvalid (out_tvalid_m),
    .out_tready (out_tready),
    .out_tdata  (out_tdata_m),
    .out_tlast  (out_tlast_m),
    .busy       (busy_m)
  );

  stream_width_serializer #(.IN_WIDTH(128), .OUT_WIDTH(32), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready_l),
    .in_tdata   (in_tdata),
    .in_tlast   (in_tlast),
    .out_tvalid (out_tvalid_l),
    .out_tready (out_tready),
    .out_tdata  (out_tdata_l),
    .out_tlast  (out_tlast_l),
    .busy       (busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated word with out_tready=1; entered and left at posedge+1.
  task automatic send_single(input int idx);
    in_tvalid = 1'b1;
    in_tdata  = vecs[idx].word;
    in_tlast  = vecs[idx].last;
    @(negedge clk);
    check("single_in_tready_idle", in_tready_m, 1);
    tick();
    in_tvalid = 1'b0;
    in_tdata  = '1;  // must be ignored while not accepting
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("single_out_tvalid", out_tvalid_m, 1);
      check("single_msb_data", out_tdata_m, vecs[idx].msb_beats[k]);
      check("single_msb_tlast", out_tlast_m, (k == 3) && vecs[idx].last);
      check("single_lsb_data", out_tdata_l, vecs[idx].lsb_beats[k]);
      check("single_lsb_tlast", out_tlast_l, (k == 3) && vecs[idx].last);
      check("single_in_tready", in_tready_m, k == 3);
      tick();
    end
    @(negedge clk);
    check("single_drained_valid", out_tvalid_m, 0);
    check("single_drained_busy", busy_m, 0);
    tick();
  endtask

  initial begin
    int  sent;
    bit  done;
    bit  acc;
    bit  prev_stall;
    logic [31:0] prev_m, prev_l;
    logic        prev_tl;
    beat_t b;

    reset_n    = 1'b0;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    in_tlast   = 1'b0;
    out_tready = 1'b0;

    vecs[0].word = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    vecs[0].last = 1'b1;
    vecs[0].msb_beats = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    vecs[0].lsb_beats = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    vecs[1].word = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
    vecs[1].last = 1'b0;
    vecs[1].msb_beats = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h01234567, 32'h89ABCDEF};
    vecs[1].lsb_beats = '{32'h89ABCDEF, 32'h01234567, 32'hCAFEBABE, 32'hDEADBEEF};
    vecs[2].word = 128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A;
    vecs[2].last = 1'b1;
    vecs[2].msb_beats = '{32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vecs[2].lsb_beats = '{32'h5A5A5A5A, 32'hA5A5A5A5, 32'h00000000, 32'hFFFFFFFF};

    // Reset held for 4 clocks.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_out_tvalid", out_tvalid_m, 0);
    check("rst_in_tready", in_tready_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_out_tlast", out_tlast_m, 0);
    tick();
    reset_n    = 1'b1;
    out_tready = 1'b1;
    @(negedge clk);
    check("rel_in_tready", in_tready_m, 1);
    check("rel_out_tvalid", out_tvalid_m, 0);
    tick();

    // Table-driven single words (both beat orders).
    for (int v = 0; v < 3; v++) send_single(v);

    // Back-to-back: three words with in_tvalid held high.
    in_tvalid = 1'b1;
    in_tdata  = vecs[0].word;
    in_tlast  = vecs[0].last;
    @(negedge clk);
    check("b2b_first_ready", in_tready_m, 1);
    tick();
    in_tdata = vecs[1].word;
    in_tlast = vecs[1].last;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("b2b_out_tvalid", out_tvalid_m, 1);
      check("b2b_msb_data", out_tdata_m, vecs[i/4].msb_beats[i%4]);
      check("b2b_msb_tlast", out_tlast_m, (i % 4 == 3) && vecs[i/4].last);
      check("b2b_in_tready", in_tready_m, i % 4 == 3);
      tick();
      if (i % 4 == 3) begin
        if (i / 4 + 2 < 3) begin
          in_tdata = vecs[i/4+2].word;
          in_tlast = vecs[i/4+2].last;
        end else begin
          in_tvalid = 1'b0;
        end
      end
    end
    @(negedge clk);
    check("b2b_drained", out_tvalid_m, 0);
    tick();

    // Random backpressure with scoreboard and stall-stability checks.
    sent       = 0;
    done       = 1'b0;
    prev_stall = 1'b0;
    prev_m     = '0;
    prev_l     = '0;
    prev_tl    = 1'b0;
    in_tvalid  = 1'b1;
    in_tdata   = {$urandom, $urandom, $urandom, $urandom};
    in_tlast   = 1'($urandom_range(0, 1));
    out_tready = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("bp_stall_valid", out_tvalid_m, 1);
        check("bp_stall_data", out_tdata_m, prev_m);
        check("bp_stall_tlast", out_tlast_m, prev_tl);
        check("bp_stall_lsb_data", out_tdata_l, prev_l);
      end
      if (out_tvalid_m && out_tready) begin
        if (sb.size() == 0) begin
          check("bp_unexpected_beat", 1, 0);
        end else begin
          b = sb.pop_front();
          check("bp_msb_data", out_tdata_m, b.d_msb);
          check("bp_msb_tlast", out_tlast_m, b.last);
          check("bp_lsb_data", out_tdata_l, b.d_lsb);
        end
      end
      prev_stall = out_tvalid_m && !out_tready;
      prev_m     = out_tdata_m;
      prev_l     = out_tdata_l;
      prev_tl    = out_tlast_m;
      acc        = in_tvalid && in_tready_m;
      if (acc) begin
        for (int k = 0; k < 4; k++) begin
          b.d_msb = in_tdata[127-32*k -: 32];
          b.d_lsb = in_tdata[32*k +: 32];
          b.last  = (k == 3) && in_tlast;
          sb.push_back(b);
        end
        sent++;
      end
      if (sent == 150 && !in_tvalid && sb.size() == 0) done = 1'b1;
      tick();
      if (acc || !in_tvalid) begin
        if (sent < 150) begin
          in_tvalid = ($urandom_range(0, 3) != 0);
          in_tdata  = {$urandom, $urandom, $urandom, $urandom};
          in_tlast  = 1'($urandom_range(0, 1));
        end else begin
          in_tvalid = 1'b0;
        end
      end
      out_tready = 1'($urandom_range(0, 1));
    end
    check("bp_completed", done, 1);
    in_tvalid  = 1'b0;
    out_tready = 1'b1;
    repeat (6) tick();

    // Reset asserted mid-word after two beats have transferred.
    in_tvalid = 1'b1;
    in_tdata  = vecs[1].word;
    in_tlast  = vecs[1].last;
    tick();
    in_tvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("mid_pre_data", out_tdata_m, vecs[1].msb_beats[k]);
      tick();
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_tvalid", out_tvalid_m, 0);
    check("mid_rst_busy", busy_m, 0);
    check("mid_rst_in_tready", in_tready_m, 0);
    check("mid_rst_out_tlast", out_tlast_m, 0);
    tick();
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rel_out_tvalid", out_tvalid_m, 0);
    check("mid_rel_in_tready", in_tready_m, 1);
    tick();
    send_single(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
